// File: rtl/chip_serializer.sv
// O-QPSK chip serializer: even chips on I, odd chips on Q offset by half a chip-pair period.
// Optional symbol counter output enabled with `define CHIP_SER_SYMCOUNT_EN.
module chip_serializer #(
    parameter int CHIP_W  = 32,
    parameter int CLK_DIV = 4
) (
    input  logic              inClk,
    input  logic              inResetN,
    input  logic [CHIP_W-1:0] inData,
    input  logic              inValid,
    output logic              outReady,
    output logic              outI,
    output logic              outQ,
    output logic              outIStrobe,
    output logic              outQStrobe,
    output logic              outBusy
`ifdef CHIP_SER_SYMCOUNT_EN
    ,
    output logic [7:0]        outSymCount
`endif
);

    localparam int PW = (CHIP_W / 2 > 1) ? $clog2(CHIP_W / 2) : 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PAIR_LAST = PW'(CHIP_W / 2 - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF  = DW'(CLK_DIV / 2);
    localparam logic [DW-1:0] DIV_PREQ  = DW'(CLK_DIV / 2 - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state_q, state_d;
    logic [CHIP_W-1:0] shift_q, shift_d;
    logic [PW-1:0]     pair_q, pair_d;
    logic [DW-1:0]     div_q, div_d;
    logic              q_q, q_d;
    logic              last_cycle;
    logic              ready_int;
    logic              take;

    always_ff @(posedge inClk or negedge inResetN) begin
        if (!inResetN) begin
            state_q <= IDLE;
            shift_q <= '0;
            pair_q  <= '0;
            div_q   <= '0;
            q_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            pair_q  <= pair_d;
            div_q   <= div_d;
            q_q     <= q_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        pair_d     = pair_q;
        div_d      = div_q;
        q_d        = q_q;
        last_cycle = (state_q == SHIFT) && (pair_q == PAIR_LAST) && (div_q == DIV_LAST);
        ready_int  = (state_q == IDLE) || last_cycle;
        take       = inValid && ready_int;

        case (state_q)
            IDLE: begin
                q_d = 1'b0;
                if (take) begin
                    state_d = SHIFT;
                    shift_d = inData;
                    pair_d  = '0;
                    div_d   = '0;
                end
            end
            SHIFT: begin
                if (take) begin
                    // Reload on the final cycle keeps the I strobe period unbroken.
                    shift_d = inData;
                    pair_d  = '0;
                    div_d   = '0;
                end else if (last_cycle) begin
                    state_d = IDLE;
                    shift_d = '0;
                    pair_d  = '0;
                    div_d   = '0;
                    q_d     = 1'b0;
                end else if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    pair_d  = pair_q + 1'b1;
                    shift_d = shift_q << 2;
                end else begin
                    div_d = div_q + 1'b1;
                    // Q is loaded one edge early so it changes exactly at the half-period strobe.
                    if (div_q == DIV_PREQ) begin
                        q_d = shift_q[CHIP_W-2];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gated with the reset input so the block refuses data while held in reset.
    assign outReady   = inResetN && ready_int;
    assign outBusy    = (state_q == SHIFT);
    assign outI       = (state_q == SHIFT) && shift_q[CHIP_W-1];
    assign outQ       = (state_q == SHIFT) && q_q;
    assign outIStrobe = (state_q == SHIFT) && (div_q == '0);
    assign outQStrobe = (state_q == SHIFT) && (div_q == DIV_HALF);

`ifdef CHIP_SER_SYMCOUNT_EN
    logic [7:0] sym_cnt_q, sym_cnt_d;

    always_ff @(posedge inClk or negedge inResetN) begin
        if (!inResetN) begin
            sym_cnt_q <= '0;
        end else begin
            sym_cnt_q <= sym_cnt_d;
        end
    end

    always_comb begin
        sym_cnt_d = sym_cnt_q;
        if (take) begin
            sym_cnt_d = sym_cnt_q + 8'd1;
        end
    end

    assign outSymCount = sym_cnt_q;
`endif

endmodule

// File: doc/chip_serializer.md
Name: chip_serializer

Overview:
- Downstream neighbour of the 4-bit-symbol-to-32-chip spreading stage; consumes one 32-bit chip word per symbol.
- Serialises each word into the two O-QPSK rails:
  - even chips go to I;
  - odd chips go to Q, delayed by half a chip-pair period.
- Valid/ready handshake on the input and a single-word holding register allow back-to-back symbols with no gap.
- The output rails feed the half-sine pulse-shaping and DAC path.

Parameters:
- CHIP_W, 32, chips per word; must be even. Chip c0 is inData[CHIP_W-1]; c(CHIP_W-1) is inData[0].
- CLK_DIV, 4, clocks per chip pair on each rail; must be even and >= 2.

Ports:
- inClk  input  1  system clock; rising-edge active.
- inResetN  input  1  asynchronous, active-low reset.
- inData  input  CHIP_W  chip word from the spreading stage.
- inValid  input  1  inData is valid.
- outReady  output  1  block accepts inData this cycle.
- outI  output  1  I-rail chip level.
- outQ  output  1  Q-rail chip level.
- outIStrobe  output  1  one-cycle pulse when outI takes a new chip.
- outQStrobe  output  1  one-cycle pulse when outQ takes a new chip.
- outBusy  output  1  a word is being serialised.

Behaviour:
- Reset (asynchronous, inResetN low):
  - state = IDLE.
  - Shift register, pair counter and divide counter cleared.
  - Outputs: outI=0, outQ=0, outIStrobe=0, outQStrobe=0, outBusy=0, outReady=0 while reset is asserted.
  - After release, outReady=1 from the first clock.
  - Reset asserted mid-word aborts the word immediately; no partial completion.
- Handshake:
  - A transfer occurs on a rising edge with inValid=1 and outReady=1.
  - inData is captured at that edge.
  - outReady is combinational from the state only, never from inValid:
    - 1 in IDLE;
    - 1 in SHIFT only on the final cycle of the final pair (pair=CHIP_W/2-1 and div=CLK_DIV-1);
    - 0 otherwise.
- State IDLE:
  - outI, outQ, outBusy and both strobes are 0.
  - On transfer: go to SHIFT with pair=0 and div=0.
- State SHIFT:
  - div counts 0..CLK_DIV-1 and wraps; pair increments on each wrap.
  - Cycle after a transfer (div=0, pair=0): outI=c0 and outIStrobe=1.
  - At div=CLK_DIV/2: outQ=c1 and outQStrobe=1. This is the half-period O-QPSK offset.
  - Pair p uses chips c(2p) on I and c(2p+1) on Q.
  - outBusy=1 throughout SHIFT.
- End of word (final cycle of the final pair):
  - Transfer present: reload, pair=0, div=0, stay in SHIFT. The next outIStrobe is exactly CLK_DIV cycles after the previous one, so there is no gap.
  - No transfer: go to IDLE. outI and outQ return to 0 on the next cycle.
- Timing:
  - Latency from the transfer edge to the first outIStrobe is 1 cycle.
  - One word lasts (CHIP_W/2)*CLK_DIV cycles, which is 64 cycles at default parameters.
- Data stability: inData may change freely after the transfer; the block serialises only the captured copy.

Optional Feature:
- Macro CHIP_SER_SYMCOUNT_EN.
- When defined:
  - Adds output outSymCount [7:0].
  - Increments by 1 on every accepted transfer and wraps 255 -> 0.
  - Reset value is 0.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- Reset, then single word with CLK_DIV=4 and inData=0xD9C3522E:
  - I sequence 1010100100010111;
  - Q sequence 1101100111000010;
  - each outQStrobe 2 cycles after its outIStrobe;
  - outBusy high for 64 cycles, then IDLE with outI=outQ=0.
- Back-to-back: inValid held high with 0xD9C3522E then 0xED9C3522:
  - outReady pulses once at cycle 63 of the first word;
  - outIStrobe period stays exactly 4 cycles across the word boundary.
- Backpressure: inValid high during SHIFT outside the final cycle:
  - outReady=0, so there is no capture;
  - the word is taken only at the end-of-word cycle;
  - a changing inData before that edge has no effect on the outputs.
- Reset mid-word: assert inResetN=0 at pair 7:
  - all outputs go to 0 asynchronously;
  - after release, outReady=1 and a new word starts with c0.
- Idle gap: second word offered 10 cycles after the first completes:
  - IDLE for those cycles with outBusy=0;
  - first outIStrobe 1 cycle after the transfer.
- With CHIP_SER_SYMCOUNT_EN: 257 accepted words leave outSymCount=1 (wrap checked).
